// File: rtl/tap_controller_if.sv
// Serial scan and boundary-chain signal bundle between the TAP controller and the test host.
// The controller takes the slave modport; the host and boundary chain take the master modport.
interface tap_controller_if #(
  parameter int unsigned IR_WIDTH = 4
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic                BSR_TDO;
  logic                BSR_CLOCK;
  logic                BSR_UPDATE;
  logic                MODE_SHIFT_LOAD;
  logic                MODE_TEST_NORMAL;
  logic [3:0]          TAP_STATE;
  logic [IR_WIDTH-1:0] IR_VALUE;

  modport master (
    output TMS, TDI, BSR_TDO,
    input  TDO, TDO_EN, BSR_CLOCK, BSR_UPDATE, MODE_SHIFT_LOAD,
    input  MODE_TEST_NORMAL, TAP_STATE, IR_VALUE
  );

  modport slave (
    input  TMS, TDI, BSR_TDO,
    output TDO, TDO_EN, BSR_CLOCK, BSR_UPDATE, MODE_SHIFT_LOAD,
    output MODE_TEST_NORMAL, TAP_STATE, IR_VALUE
  );
endinterface

// File: rtl/tap_controller.sv
// 1149.1 TAP controller: 16-state FSM, IR/bypass/IDCODE registers and boundary-chain strobes.
// The boundary-chain strobes are gated by TCK low, so the chain sees rising edges at mid-cycle.
module tap_controller #(
  parameter int unsigned         IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = IR_WIDTH'(4'b0000),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE    = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(4'b0011),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS    = IR_WIDTH'(4'b1111)
) (
  input  logic             TCK,
  input  logic             TRST_N,
  tap_controller_if.slave  tap
);

  localparam int unsigned ID_WIDTH = 32;

  typedef enum logic [3:0] {
    ST_EX2_DR = 4'h0,
    ST_EX1_DR = 4'h1,
    ST_SH_DR  = 4'h2,
    ST_PAU_DR = 4'h3,
    ST_SEL_IR = 4'h4,
    ST_UPD_DR = 4'h5,
    ST_CAP_DR = 4'h6,
    ST_SEL_DR = 4'h7,
    ST_EX2_IR = 4'h8,
    ST_EX1_IR = 4'h9,
    ST_SH_IR  = 4'hA,
    ST_PAU_IR = 4'hB,
    ST_RTI    = 4'hC,
    ST_UPD_IR = 4'hD,
    ST_CAP_IR = 4'hE,
    ST_TLR    = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BSR
  } dr_sel_e;

  tap_state_e           state_q, state_d;
  logic [IR_WIDTH-1:0]  ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]  ir_value_q, ir_value_d;
  logic                 bypass_q, bypass_d;
  logic [ID_WIDTH-1:0]  id_shift_q, id_shift_d;
  logic                 bsr_clk_en_q, bsr_clk_en_d;
  logic                 upd_en_q, upd_en_d;
  dr_sel_e              dr_sel;
  logic                 tdo_c;

  // Data-register selection follows the active instruction; undefined opcodes fall to bypass.
  always_comb begin
    dr_sel = DR_BYPASS;
    if ((ir_value_q == OP_EXTEST) || (ir_value_q == OP_SAMPLE)) begin
      dr_sel = DR_BSR;
    end else if (ir_value_q == OP_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if (ir_value_q == OP_BYPASS) begin
      dr_sel = DR_BYPASS;
    end
  end

  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      state_q      <= ST_TLR;
      ir_shift_q   <= '0;
      ir_value_q   <= OP_IDCODE;
      bypass_q     <= 1'b0;
      id_shift_q   <= '0;
      bsr_clk_en_q <= 1'b0;
      upd_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_shift_q   <= ir_shift_d;
      ir_value_q   <= ir_value_d;
      bypass_q     <= bypass_d;
      id_shift_q   <= id_shift_d;
      bsr_clk_en_q <= bsr_clk_en_d;
      upd_en_q     <= upd_en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_shift_d   = ir_shift_q;
    ir_value_d   = ir_value_q;
    bypass_d     = bypass_q;
    id_shift_d   = id_shift_q;
    bsr_clk_en_d = 1'b0;
    upd_en_d     = 1'b0;

    case (state_q)
      ST_TLR:    state_d = tap.TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = tap.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = tap.TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = tap.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = tap.TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = tap.TMS ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: state_d = tap.TMS ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: state_d = tap.TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = tap.TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = tap.TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = tap.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = tap.TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = tap.TMS ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: state_d = tap.TMS ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: state_d = tap.TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = tap.TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase

    // Register actions take effect on the edge that leaves the named state.
    case (state_q)
      ST_CAP_IR: ir_shift_d = IR_WIDTH'(2'b01);
      ST_SH_IR:  ir_shift_d = {tap.TDI, ir_shift_q[IR_WIDTH-1:1]};
      ST_UPD_IR: ir_value_d = ir_shift_q;
      ST_CAP_DR: begin
        bypass_d   = 1'b0;
        id_shift_d = IDCODE_VALUE;
      end
      ST_SH_DR: begin
        case (dr_sel)
          DR_BYPASS: bypass_d   = tap.TDI;
          DR_IDCODE: id_shift_d = {tap.TDI, id_shift_q[ID_WIDTH-1:1]};
          default:   ;
        endcase
      end
      default: ;
    endcase

    // Forcing on entry keeps IR_VALUE at IDCODE for every cycle spent in TLR.
    if (state_d == ST_TLR) begin
      ir_value_d = OP_IDCODE;
    end

    bsr_clk_en_d = (dr_sel == DR_BSR) && ((state_d == ST_CAP_DR) || (state_d == ST_SH_DR));
    upd_en_d     = (dr_sel == DR_BSR) && (state_d == ST_UPD_DR);
  end

  always_comb begin
    tdo_c = 1'b0;
    if (state_q == ST_SH_IR) begin
      tdo_c = ir_shift_q[0];
    end else if (state_q == ST_SH_DR) begin
      case (dr_sel)
        DR_BSR:    tdo_c = tap.BSR_TDO;
        DR_IDCODE: tdo_c = id_shift_q[0];
        default:   tdo_c = bypass_q;
      endcase
    end
  end

  // Enables only move on posedge while ~TCK is low, so the gated strobes cannot glitch.
  assign tap.BSR_CLOCK        = ~TCK & bsr_clk_en_q;
  assign tap.BSR_UPDATE       = ~TCK & upd_en_q;
  assign tap.TDO              = tdo_c;
  assign tap.TDO_EN           = (state_q == ST_SH_IR) || (state_q == ST_SH_DR);
  assign tap.MODE_SHIFT_LOAD  = (state_q == ST_CAP_DR);
  assign tap.MODE_TEST_NORMAL = (ir_value_q != OP_EXTEST);
  assign tap.TAP_STATE        = state_q;
  assign tap.IR_VALUE         = ir_value_q;

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: drives TMS/TDI, models a 3-cell boundary chain and
// scoreboards every TDO bit presented while TDO_EN is high.
module tb_tap_controller;

  localparam int unsigned IR_W = 4;
  localparam logic [31:0] IDCODE = 32'h1000_0001;
  localparam logic [2:0]  SYS_PINS = 3'b011;

  logic tck = 1'b0;
  logic trst_n;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];

  logic [2:0] cap = '0;
  logic [2:0] upd = '0;
  int clk_edges = 0;
  int sl_edges = 0;
  int upd_edges = 0;

  tap_controller_if #(.IR_WIDTH(IR_W)) tif ();

  tap_controller #(.IR_WIDTH(IR_W)) dut (
    .TCK    (tck),
    .TRST_N (trst_n),
    .tap    (tif.slave)
  );

  always #5 tck = ~tck;

  // Boundary chain: cell 0 fed by TDI, cell 2 drives BSR_TDO.
  assign tif.BSR_TDO = cap[2];

  always @(posedge tif.BSR_CLOCK) begin
    if (tif.MODE_SHIFT_LOAD) begin
      cap      <= SYS_PINS;
      sl_edges <= sl_edges + 1;
    end else begin
      cap <= {cap[1:0], tif.TDI};
    end
    clk_edges <= clk_edges + 1;
  end

  always @(posedge tif.BSR_UPDATE) begin
    upd       <= cap;
    upd_edges <= upd_edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected bit per shift cycle, sampled mid-high-phase.
  always @(posedge tck) begin
    logic e;
    #3;
    if (tif.TDO_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tdo_unexpected: got TDO_EN=1 in state %0h, expected no shift", tif.TAP_STATE);
      end else begin
        e = exp_q.pop_front();
        chk("tdo", 32'(tif.TDO), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick(input logic tms, input logic tdi);
    tif.TMS = tms;
    tif.TDI = tdi;
    @(posedge tck);
    #1;
  endtask

  // Shift n bits from a Shift state; the last bit exits with TMS=1.
  task automatic shift_seq(input int n, input logic [31:0] tdi_bits, input logic [31:0] exp_bits);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_bits[i]);
      tick(i == n - 1, tdi_bits[i]);
    end
  endtask

  task automatic load_ir(input logic [IR_W-1:0] op);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shift_seq(IR_W, 32'(op), 32'h1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("ir_value_load", 32'(tif.IR_VALUE), 32'(op));
  endtask

  task automatic dr_scan(input int n, input logic [31:0] tdi_bits, input logic [31:0] exp_bits);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    if (n > 0) begin
      tick(1'b0, 1'b0);
      shift_seq(n, tdi_bits, exp_bits);
    end else begin
      tick(1'b1, 1'b0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    int c0, s0, u0;
    trst_n  = 1'b0;
    tif.TMS = 1'b1;
    tif.TDI = 1'b0;
    repeat (2) @(posedge tck);
    #1;

    // Reset values
    chk("rst_state", 32'(tif.TAP_STATE), 32'hF);
    chk("rst_ir", 32'(tif.IR_VALUE), 32'h3);
    chk("rst_tdo", 32'(tif.TDO), 32'h0);
    chk("rst_tdo_en", 32'(tif.TDO_EN), 32'h0);
    chk("rst_shift_load", 32'(tif.MODE_SHIFT_LOAD), 32'h0);
    chk("rst_test_normal", 32'(tif.MODE_TEST_NORMAL), 32'h1);
    #5;
    chk("rst_bsr_clock", 32'(tif.BSR_CLOCK), 32'h0);
    chk("rst_bsr_update", 32'(tif.BSR_UPDATE), 32'h0);
    trst_n = 1'b1;

    // IDCODE readout
    tick(1'b0, 1'b0);
    chk("rti_state", 32'(tif.TAP_STATE), 32'hC);
    c0 = clk_edges;
    dr_scan(32, 32'h0, IDCODE);
    chk("idcode_no_bsr_clk", 32'(clk_edges - c0), 32'h0);
    chk("idcode_ir_kept", 32'(tif.IR_VALUE), 32'h3);

    // Bypass: one-bit delay, no chain strobes
    load_ir(4'hF);
    chk("bypass_test_normal", 32'(tif.MODE_TEST_NORMAL), 32'h1);
    c0 = clk_edges;
    u0 = upd_edges;
    dr_scan(3, 32'b101, 32'b010);
    chk("bypass_no_bsr_clk", 32'(clk_edges - c0), 32'h0);
    chk("bypass_no_bsr_upd", 32'(upd_edges - u0), 32'h0);

    // EXTEST through the 3-cell chain
    load_ir(4'h0);
    chk("extest_test_normal", 32'(tif.MODE_TEST_NORMAL), 32'h0);
    c0 = clk_edges;
    s0 = sl_edges;
    u0 = upd_edges;
    dr_scan(3, 32'b101, 32'b110);
    chk("extest_clk_edges", 32'(clk_edges - c0), 32'd4);
    chk("extest_load_edges", 32'(sl_edges - s0), 32'd1);
    chk("extest_upd_edges", 32'(upd_edges - u0), 32'd1);
    chk("extest_pins", 32'(upd), 32'b101);

    // Zero-length shift updates with captured data
    c0 = clk_edges;
    u0 = upd_edges;
    dr_scan(0, 32'h0, 32'h0);
    chk("zlen_clk_edges", 32'(clk_edges - c0), 32'd1);
    chk("zlen_upd_edges", 32'(upd_edges - u0), 32'd1);
    chk("zlen_pins", 32'(upd), 32'(SYS_PINS));

    // SAMPLE: chain still clocked, normal mode
    load_ir(4'h2);
    chk("sample_test_normal", 32'(tif.MODE_TEST_NORMAL), 32'h1);
    c0 = clk_edges;
    u0 = upd_edges;
    dr_scan(1, 32'h0, 32'h0);
    chk("sample_clk_edges", 32'(clk_edges - c0), 32'd2);
    chk("sample_upd_edges", 32'(upd_edges - u0), 32'd1);
    chk("sample_pins", 32'(upd), 32'b110);
    chk("sample_test_normal_after", 32'(tif.MODE_TEST_NORMAL), 32'h1);

    // Reset during the second Shift-IR cycle
    u0 = upd_edges;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    exp_q.push_back(1'b1);
    tick(1'b0, 1'b1);
    exp_q.push_back(1'b0);
    trst_n = 1'b0;
    tick(1'b0, 1'b0);
    trst_n = 1'b1;
    chk("midrst_state", 32'(tif.TAP_STATE), 32'hF);
    chk("midrst_ir", 32'(tif.IR_VALUE), 32'h3);
    chk("midrst_tdo", 32'(tif.TDO), 32'h0);
    chk("midrst_tdo_en", 32'(tif.TDO_EN), 32'h0);
    tick(1'b1, 1'b0);
    chk("midrst_no_upd", 32'(upd_edges - u0), 32'h0);
    chk("midrst_tlr_hold", 32'(tif.TAP_STATE), 32'hF);

    // Five TMS=1 from Pause-DR reach TLR and force IDCODE
    tick(1'b0, 1'b0);
    load_ir(4'hF);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("walk_paudr", 32'(tif.TAP_STATE), 32'h3);
    repeat (5) tick(1'b1, 1'b0);
    chk("tlr_state", 32'(tif.TAP_STATE), 32'hF);
    chk("tlr_ir", 32'(tif.IR_VALUE), 32'h3);
    chk("tlr_test_normal", 32'(tif.MODE_TEST_NORMAL), 32'h1);

    tick(1'b1, 1'b0);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1-style TAP controller. It is the stage directly upstream of the boundary-scan cell chain.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register, bypass register and IDCODE register.
- Generates the boundary-chain control signals: BSR_CLOCK (cell capture/shift clock), BSR_UPDATE, MODE_SHIFT_LOAD and MODE_TEST_NORMAL.
- Muxes the selected scan path onto TDO.

Parameters:
- IR_WIDTH, 4: instruction register width.
- IDCODE_VALUE, 32'h1000_0001: device ID; bit 0 must be 1.
- OP_EXTEST, 4'b0000: boundary chain selected, test mode.
- OP_SAMPLE, 4'b0010: SAMPLE/PRELOAD, boundary chain selected, normal mode.
- OP_IDCODE, 4'b0011: ID register selected.
- OP_BYPASS, 4'b1111: bypass selected. Any undefined opcode also selects bypass.

Ports:
- TCK, input, 1: the single clock. All registers update on posedge TCK.
- TRST_N, input, 1: reset, synchronous, active-low, sampled on posedge TCK.
- TMS, input, 1: mode select.
- TDI, input, 1: serial data in. Also drives the first boundary cell's TDIS.
- TDO, output, 1: serial data out.
- TDO_EN, output, 1: 1 while in Shift-IR or Shift-DR.
- BSR_TDO, input, 1: TDOS of the last boundary cell.
- BSR_CLOCK, output, 1: drives the CAPTURE inputs of the cells.
- BSR_UPDATE, output, 1: drives the UPDATE inputs of the cells.
- MODE_SHIFT_LOAD, output, 1: 1 = cells load system data, 0 = cells shift.
- MODE_TEST_NORMAL, output, 1: 1 = system data passes through, 0 = update registers drive the pins.
- TAP_STATE, output, 4: current FSM state.
- IR_VALUE, output, IR_WIDTH: active (updated) instruction.

Behaviour:
- **State encoding and transitions.** Standard 1149.1 encoding; each line gives TMS=0 target / TMS=1 target.
  - TLR F: RTI / TLR
  - RTI C: RTI / SelDR
  - SelDR 7: CapDR / SelIR
  - CapDR 6: ShDR / Ex1DR
  - ShDR 2: ShDR / Ex1DR
  - Ex1DR 1: PauDR / UpdDR
  - PauDR 3: PauDR / Ex2DR
  - Ex2DR 0: ShDR / UpdDR
  - UpdDR 5: RTI / SelDR
  - SelIR 4: CapIR / TLR
  - CapIR E: ShIR / Ex1IR
  - ShIR A: ShIR / Ex1IR
  - Ex1IR 9: PauIR / UpdIR
  - PauIR B: PauIR / Ex2IR
  - Ex2IR 8: ShIR / UpdIR
  - UpdIR D: RTI / SelDR
- **Reset.** TRST_N=0 at a posedge has priority over everything. Same edge sets:
  - state = TLR
  - IR_VALUE = OP_IDCODE
  - ir_shift = 0, bypass = 0, id_shift = 0
- **Test-Logic-Reset.** While in TLR, IR_VALUE is forced to OP_IDCODE every cycle. Five TMS=1 cycles reach TLR from any state.
- **IR path.**
  - CapIR: ir_shift <= {0…,2'b01}.
  - ShIR: ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
  - UpdIR: IR_VALUE <= ir_shift.
  - Pause and Exit states hold all values.
- **DR select** is decoded from IR_VALUE:
  - EXTEST or SAMPLE: boundary chain.
  - IDCODE: 32-bit id_shift.
  - anything else: 1-bit bypass.
- **DR path (internal registers).**
  - CapDR: bypass <= 0; id_shift <= IDCODE_VALUE.
  - ShDR: the selected register shifts right with TDI entering the MSB.
  - Non-selected registers hold.
- **TDO.** Combinational.
  - ShIR: ir_shift[0].
  - ShDR: LSB of the selected register, or BSR_TDO when the boundary chain is selected.
  - All other states: 0.
- **Boundary-chain strobes.**
  - bsr_clk_en is registered: 1 iff next state ∈ {CapDR, ShDR} and the boundary chain is selected.
  - BSR_CLOCK = ~TCK & bsr_clk_en. Rising edge at mid-cycle (negedge TCK) of each CapDR/ShDR cycle. Glitch-free, because the enable only changes while ~TCK is low.
  - BSR_UPDATE = ~TCK & upd_en, where upd_en is registered: 1 iff next state = UpdDR and boundary selected. Exactly one rising edge per UpdDR visit.
  - Neither strobe pulses when bypass or IDCODE is selected.
  - Both strobes are 0 during and after reset.
- **Cell mode signals.**
  - MODE_SHIFT_LOAD = (state==CapDR). It is stable across the mid-cycle edge.
  - MODE_TEST_NORMAL = 0 iff IR_VALUE==OP_EXTEST. It changes only at UpdIR or reset.
- **Reset values of outputs.**
  - TAP_STATE: F
  - IR_VALUE: OP_IDCODE
  - TDO: 0
  - TDO_EN: 0
  - BSR_CLOCK: 0
  - BSR_UPDATE: 0
  - MODE_SHIFT_LOAD: 0
  - MODE_TEST_NORMAL: 1
- **Reset during a shift.** Any partial shift is discarded and IR_VALUE is not updated from ir_shift.
- **Zero-length shift.** CapDR→Ex1DR→UpdDR with no Shift cycles still updates, using the captured data.

Test Plan:
- **Reset / TLR entry.** TRST_N=0 for 1 cycle, then 5×TMS=1 from a random state → TAP_STATE=F, IR_VALUE=0011, MODE_TEST_NORMAL=1.
- **IDCODE readout.** After reset, TMS 0,1,0,0 to reach ShDR, then 32 shifts → TDO sequence LSB-first = 32'h1000_0001; TDO_EN=1 only in ShDR.
- **IR capture and load.**
  - Shift IR with TDI=1111 → first two TDO bits are 1,0 and IR_VALUE=1111 after UpdIR.
  - Then shift DR with TDI=1,0,1 → TDO = 0,1,0 (one-bit bypass delay).
  - Zero BSR_CLOCK pulses during this.
- **EXTEST with 3 loopback cells.**
  - Load OP_EXTEST → MODE_TEST_NORMAL=0.
  - CapDR then 3 ShDR cycles → exactly 4 BSR_CLOCK rising edges.
  - MODE_SHIFT_LOAD=1 only on the first edge.
  - After UpdDR: 1 BSR_UPDATE edge and the cell outputs equal the shifted pattern 101.
- **SAMPLE vs EXTEST mode.** Load OP_SAMPLE → MODE_TEST_NORMAL=1 while BSR_CLOCK still pulses in CapDR/ShDR.
- **Reset mid-shift.** TRST_N=0 during the 2nd ShIR cycle → next cycle TAP_STATE=F, IR_VALUE=0011, no BSR_UPDATE pulse, TDO=0.
